// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the synchronous instruction memory.
//   state_t   - controller state (CLEAR: self-zeroing after reset, RUN: serving traffic)
//   FLT_*     - fetch fault codes driven on fault_o
//   NOP_WORD  - word returned on a faulted fetch (sll $0,$0,0)
package imem_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [1:0] FLT_OK       = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;

  localparam int NOP_WORD = 0;

endpackage

// File: rtl/imem_ram_1r1w.sv
// imem_ram_1r1w: DEPTH x DATA_W word array, one registered read port and one
// write port. A read and write to the same word in one cycle returns the old
// data (read-first).
//   clk, rst          - clock, synchronous active-high reset (clears rd_data only)
//   rd_en, rd_addr    - read strobe / word index; rd_data valid after the edge
//   wr_en, wr_addr,
//   wr_data           - write strobe / word index / data
module imem_ram_1r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports update with non-blocking assignments on the same edge, so a
  // same-address read samples the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/imem_sync.sv
// imem_sync: synchronous instruction memory for the fetch stage.
// After reset the array is zeroed one word per cycle (CLEAR), then fetch and
// load traffic is accepted (RUN).
//   clk_i, rst_i        - clock, synchronous active-high reset
//   req_i, pc_addr_i    - fetch request / byte address
//   ready_o             - memory accepting traffic
//   rsp_valid_o,
//   instr_o, fault_o    - registered fetch response (1-cycle latency)
//   ld_we_i, ld_addr_i,
//   ld_data_i           - program-load word write
//   ld_err_o            - pulse: previous cycle's load was dropped
module imem_sync
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 128
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] pc_addr_i,
  output logic              ready_o,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [1:0]        fault_o,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]     CNT_LAST  = AW'(DEPTH - 1);
  // Full-width index bound: addresses past the array fault instead of aliasing.
  localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);

  state_t            state;
  logic [AW-1:0]     cnt;
  logic [ADDR_W-3:0] f_idx, l_idx;
  logic [1:0]        f_flt;
  logic              ld_ok;
  logic              rd_en;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  assign f_idx = pc_addr_i[ADDR_W-1:2];
  assign l_idx = ld_addr_i[ADDR_W-1:2];

  // Misaligned outranks out-of-range.
  always_comb begin
    f_flt = FLT_OK;
    if (pc_addr_i[1:0] != 2'b00)  f_flt = FLT_MISALIGN;
    else if (f_idx >= DEPTH_IDX)  f_flt = FLT_RANGE;
  end

  assign ld_ok = (ld_addr_i[1:0] == 2'b00) && (l_idx < DEPTH_IDX);

  // Faulted fetches skip the array; their data is masked at the output anyway.
  assign rd_en = (state == RUN) && req_i && (f_flt == FLT_OK);

  // Write port belongs to the clear counter in CLEAR, to the load port in RUN.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = l_idx[AW-1:0];
    wr_data = ld_data_i;
    if (state == CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = cnt;
      wr_data = '0;
    end else begin
      wr_en   = ld_we_i && ld_ok;
    end
  end

  imem_ram_1r1w #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk_i),
    .rst     (rst_i),
    .rd_en   (rd_en),
    .rd_addr (f_idx[AW-1:0]),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // rd_data and fault_o both hold when no request is taken, so instr_o holds too.
  assign instr_o = (fault_o == FLT_OK) ? rd_data : DATA_W'(NOP_WORD);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= CLEAR;
      cnt         <= '0;
      ready_o     <= 1'b0;
      rsp_valid_o <= 1'b0;
      fault_o     <= FLT_OK;
      ld_err_o    <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          rsp_valid_o <= 1'b0;
          ld_err_o    <= 1'b0;
          cnt         <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state   <= RUN;
            ready_o <= 1'b1;
          end
        end
        RUN: begin
          rsp_valid_o <= req_i;
          if (req_i) fault_o <= f_flt;
          ld_err_o    <= ld_we_i && !ld_ok;
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync: directed self-checking bench for imem_sync (DEPTH=128).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. reflecting the edge just taken.
module tb_imem_sync;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 128;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              req_i;
  logic [ADDR_W-1:0] pc_addr_i;
  logic              ready_o;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] instr_o;
  logic [1:0]        fault_o;
  logic              ld_we_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [DATA_W-1:0] ld_data_i;
  logic              ld_err_o;

  int n_cmp = 0;
  int n_err = 0;

  imem_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .pc_addr_i   (pc_addr_i),
    .ready_o     (ready_o),
    .rsp_valid_o (rsp_valid_o),
    .instr_o     (instr_o),
    .fault_o     (fault_o),
    .ld_we_i     (ld_we_i),
    .ld_addr_i   (ld_addr_i),
    .ld_data_i   (ld_data_i),
    .ld_err_o    (ld_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rsp(input string tag, input logic v, input logic [31:0] d, input logic [1:0] f);
    chk({tag, ".valid"}, 32'(rsp_valid_o), 32'(v));
    chk({tag, ".instr"}, instr_o, d);
    chk({tag, ".fault"}, 32'(fault_o), 32'(f));
  endtask

  // Expects ready_o low before each of DEPTH edges, high after the last one;
  // rsp_valid_o must stay low throughout even with req_i held high.
  task automatic clear_phase(input string tag);
    int bad_rdy = 0;
    int bad_vld = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready_o !== 1'b0)     bad_rdy++;
      if (rsp_valid_o !== 1'b0) bad_vld++;
      step();
    end
    if (rsp_valid_o !== 1'b0) bad_vld++;
    chk({tag, ".ready_low_cycles_bad"}, 32'(bad_rdy), 32'd0);
    chk({tag, ".valid_low_cycles_bad"}, 32'(bad_vld), 32'd0);
    chk({tag, ".ready_after_clear"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    rst_i = 1'b1; req_i = 1'b1; pc_addr_i = '0;
    ld_we_i = 1'b0; ld_addr_i = '0; ld_data_i = '0;
    step(); step();
    chk("rst.ready",  32'(ready_o), 32'd0);
    chk("rst.ld_err", 32'(ld_err_o), 32'd0);
    rsp("rst", 1'b0, 32'h0, 2'b00);

    // Release reset with a request pending: 128 CLEAR cycles, then RUN.
    rst_i = 1'b0;
    clear_phase("clr1");

    // First fetch of 0x0 after clear.
    pc_addr_i = 32'h0; step();
    rsp("fetch0", 1'b1, 32'h0, 2'b00);

    // Load word[2], fetch it back.
    req_i = 1'b0; ld_we_i = 1'b1; ld_addr_i = 32'h8; ld_data_i = 32'h2008_0005; step();
    chk("ld2.valid", 32'(rsp_valid_o), 32'd0);
    chk("ld2.ld_err", 32'(ld_err_o), 32'd0);
    ld_we_i = 1'b0; req_i = 1'b1; pc_addr_i = 32'h8; step();
    rsp("fetch8", 1'b1, 32'h2008_0005, 2'b00);

    // Fault cases, back to back.
    pc_addr_i = 32'h6;   step(); rsp("fetch6",   1'b1, 32'h0, 2'b01);
    pc_addr_i = 32'h200; step(); rsp("fetch200", 1'b1, 32'h0, 2'b10);
    pc_addr_i = 32'h202; step(); rsp("fetch202", 1'b1, 32'h0, 2'b01);
    pc_addr_i = 32'h8000_0000; step(); rsp("fetchhi", 1'b1, 32'h0, 2'b10);

    // Same-cycle load and fetch of word 0: read-first.
    pc_addr_i = 32'h0; ld_we_i = 1'b1; ld_addr_i = 32'h0; ld_data_i = 32'hAAAA_0000; step();
    rsp("rf.old", 1'b1, 32'h0, 2'b00);
    ld_we_i = 1'b0; step();
    rsp("rf.new", 1'b1, 32'hAAAA_0000, 2'b00);

    // No request: valid drops, data/fault hold.
    req_i = 1'b0; step();
    rsp("idle", 1'b0, 32'hAAAA_0000, 2'b00);

    // Dropped loads: misaligned, then out of range (both would alias word 0).
    ld_we_i = 1'b1; ld_addr_i = 32'h3; ld_data_i = 32'hDEAD_BEEF; step();
    chk("lderr.mis", 32'(ld_err_o), 32'd1);
    ld_addr_i = 32'h400; step();
    chk("lderr.rng", 32'(ld_err_o), 32'd1);
    ld_we_i = 1'b0; req_i = 1'b1; pc_addr_i = 32'h0; step();
    chk("lderr.clr", 32'(ld_err_o), 32'd0);
    rsp("lderr.word0", 1'b1, 32'hAAAA_0000, 2'b00);

    // Last word of the array.
    req_i = 1'b0; ld_we_i = 1'b1; ld_addr_i = 32'h1FC; ld_data_i = 32'hCAFE_F00D; step();
    chk("ldlast.ld_err", 32'(ld_err_o), 32'd0);
    ld_we_i = 1'b0; req_i = 1'b1; pc_addr_i = 32'h1FC; step();
    rsp("fetchlast", 1'b1, 32'hCAFE_F00D, 2'b00);

    // Load word[5], then reset mid-stream with a request in flight.
    req_i = 1'b0; ld_we_i = 1'b1; ld_addr_i = 32'h14; ld_data_i = 32'h1234_5678; step();
    ld_we_i = 1'b0; req_i = 1'b1; pc_addr_i = 32'h14; step();
    rsp("fetch14", 1'b1, 32'h1234_5678, 2'b00);
    rst_i = 1'b1; step();
    chk("mrst.ready", 32'(ready_o), 32'd0);
    rsp("mrst", 1'b0, 32'h0, 2'b00);
    rst_i = 1'b0;
    clear_phase("clr2");
    step();
    rsp("post.fetch14", 1'b1, 32'h0, 2'b00);
    pc_addr_i = 32'h8; step();
    rsp("post.fetch8", 1'b1, 32'h0, 2'b00);
    pc_addr_i = 32'h1FC; step();
    rsp("post.fetchlast", 1'b1, 32'h0, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
